// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Feeds the four-digit 7-segment decoder with one BCD digit per byte on DIGITS.
// Optional build macro BCD_OVF_SATURATE_EN: when defined, out-of-range inputs
// (> 9999) show 9999 instead of the value modulo 10000. OVF is reported either way.
module bin_to_bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [BIN_W-1:0] BIN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [31:0]      DIGITS,
  output logic             OUT_VALID,
  output logic             OVF
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CNT_W = 5;

  state_t             r_state;
  state_t             w_nextState;

  logic [BIN_W-1:0]   r_bin;
  logic [15:0]        r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovfCap;
  logic [31:0]        r_digits;
  logic               r_ovf;

  logic               w_accept;
  logic               w_lastShift;
  logic               w_binOver;
  logic [2:0]         w_topAdj;
  logic [3:0]         w_hunAdj;
  logic [3:0]         w_tenAdj;
  logic [3:0]         w_oneAdj;
  logic [15:0]        w_accShift;
  logic [31:0]        w_packed;
  logic [31:0]        w_digitsNext;

  assign w_accept    = IN_VALID && (r_state == S_IDLE);
  assign w_lastShift = (r_state == S_SHIFT) && (r_cnt == 5'd1);

  // Zero-extended so the same compare works for every legal BIN_W.
  assign w_binOver = ({{(32-BIN_W){1'b0}}, BIN} > 32'd9999);

  // Add-3 correction for each digit that will overflow past 9 when doubled.
  // Only the low three bits of the thousands digit survive the shift, which
  // is how the carry into a fifth digit is discarded.
  assign w_oneAdj = (r_acc[3:0]   >= 4'd5) ? r_acc[3:0]   + 4'd3 : r_acc[3:0];
  assign w_tenAdj = (r_acc[7:4]   >= 4'd5) ? r_acc[7:4]   + 4'd3 : r_acc[7:4];
  assign w_hunAdj = (r_acc[11:8]  >= 4'd5) ? r_acc[11:8]  + 4'd3 : r_acc[11:8];
  assign w_topAdj = (r_acc[15:12] >= 4'd5) ? 3'(r_acc[15:12] + 4'd3) : r_acc[14:12];

  assign w_accShift = {w_topAdj, w_hunAdj, w_tenAdj, w_oneAdj, r_bin[BIN_W-1]};

  // One byte per digit, high nibble zero, so the decoder inputs wire straight on.
  assign w_packed = {4'h0, w_accShift[15:12],
                     4'h0, w_accShift[11:8],
                     4'h0, w_accShift[7:4],
                     4'h0, w_accShift[3:0]};

`ifdef BCD_OVF_SATURATE_EN
  assign w_digitsNext = r_ovfCap ? 32'h09090909 : w_packed;
`else
  assign w_digitsNext = w_packed;
`endif

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: idle until a handshake, shift BIN_W times, one done cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (IN_VALID) w_nextState = S_SHIFT;
      S_SHIFT: if (r_cnt == 5'd1) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only, so they follow reset at once.
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (r_state)
      S_IDLE:  IN_READY  = 1'b1;
      S_DONE:  OUT_VALID = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, shift-add-3 while shifting, and publish the
  // finished digits on the edge into DONE so they are valid with OUT_VALID.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bin    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovfCap <= 1'b0;
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_bin    <= BIN;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(BIN_W);
      r_ovfCap <= w_binOver;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_accShift;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 5'd1;
      if (w_lastShift) begin
        r_digits <= w_digitsNext;
        r_ovf    <= r_ovfCap;
      end
    end
  end

  assign DIGITS = r_digits;
  assign OVF    = r_ovf;

endmodule
